mult_hilo_ctrl: RTL and testbench
=================================

MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, giving the max cycles in WAIT before abort.
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
- Clk  in  1  single clock, all logic on rising edge.
- Rst  in  1  reset, synchronous and active-high.
- MultReq  in  1  pipeline request to multiply OpA*OpB.
- OpA  in  16  multiplicand from pipeline.
- OpB  in  16  multiplier operand from pipeline.
- MtHi  in  1  write HiIn into HI.
- MtLo  in  1  write LoIn into LO.
- HiIn  in  16  data for MtHi.
- LoIn  in  16  data for MtLo.
- Idle  in  1  multiplier core idle.
- Done  in  1  multiplier core result ready.
- Produto  in  32  multiplier core product.
- St  out  1  start pulse to multiplier core.
- Multiplicando  out  16  registered operand A to core.
- Multiplicador  out  16  registered operand B to core.
- Busy  out  1  stall to pipeline.
- ResultValid  out  1  one-cycle pulse when HI/LO updated by a multiply.
- Err  out  1  one-cycle pulse on timeout abort.
- HiOut  out  16  HI register value.
- LoOut  out  16  LO register value.

Function
REQ-003 SHALL implement FSM states IDLE, ZERO, LAUNCH, WAIT, WRITE.
REQ-004 In IDLE, SHALL accept MultReq only when Idle=1; MultReq with Idle=0 SHALL be ignored and Busy SHALL be 1.
REQ-005 On accept, SHALL latch OpA/OpB into Multiplicando/Multiplicador.
- If OpA=0 or OpB=0, next state ZERO.
- Otherwise, next state LAUNCH.
REQ-006 In ZERO, SHALL not assert St.
- HI/LO SHALL load 0 at end of the cycle.
- ResultValid SHALL be 1 for that cycle.
- Next state IDLE.
REQ-007 In LAUNCH, SHALL assert St for exactly one cycle, then go to WAIT; operands SHALL stay stable from LAUNCH through WAIT.
REQ-008 In WAIT, on Done=1, SHALL capture HI=Produto[31:16] and LO=Produto[15:0], then go to WRITE.
REQ-009 In WRITE, SHALL pulse ResultValid for one cycle, then go to IDLE.
- Latency: ResultValid is high the cycle after the edge sampling Done=1.
REQ-010 Timeout counter:
- SHALL be cleared on entering WAIT and increment each WAIT cycle.
- When it reaches TIMEOUT without Done, SHALL pulse Err for one cycle, go to IDLE, and leave HI/LO unchanged.
REQ-011 Busy SHALL be 1 in ZERO, LAUNCH, WAIT and WRITE, and in IDLE while MultReq=1 and Idle=0; otherwise 0.
REQ-012 MultReq while not in IDLE SHALL be ignored; the pipeline holds the request via Busy.
REQ-013 MtHi/MtLo SHALL write HI/LO only in IDLE with no MultReq accepted that cycle.
- Otherwise they SHALL be ignored.
- MtHi and MtLo together SHALL write both registers.
REQ-014 Done sampled in any state other than WAIT SHALL be ignored (stale results discarded).
REQ-015 HiOut/LoOut SHALL be direct register outputs, with no combinational bypass from Produto.

Reset
REQ-016 Rst=1 at a rising edge SHALL force, regardless of state (including mid-WAIT):
- state IDLE;
- St, Busy, ResultValid, Err = 0;
- Multiplicando, Multiplicador, HI, LO = 0;
- timeout counter = 0.
REQ-017 After reset, SHALL accept a new request only once Idle=1, so an in-flight core operation drains first.

Verification
REQ-018 Bench SHALL cover these directed scenarios:
- OpA=2, OpB=10, MultReq one cycle, core returns Done -> one St pulse, HiOut=0x0000, LoOut=0x0014, ResultValid one cycle.
- OpA=15, OpB=15 -> HiOut=0x0000, LoOut=0x00E1.
- OpA=0, OpB=0xFFFF -> St never asserted, HiOut=LoOut=0x0000, ResultValid on 2nd cycle after accept.
- OpA=0xFFFF, OpB=0xFFFF -> HiOut=0xFFFE, LoOut=0x0001.
- Done held 0 in WAIT -> Err pulse after exactly TIMEOUT WAIT cycles, HI/LO keep prior values, Busy drops.
- Rst asserted mid-WAIT, then Done arrives -> outputs zero, Done ignored; then MtHi with HiIn=0x1234 -> HiOut=0x1234.

Source files
------------

// File: rtl/mult_hilo_ctrl.sv
// rtl/mult_hilo_ctrl.sv - HI/LO multiply controller between pipeline and multiplier core
//
// Purpose:
//    Accepts multiply requests from the pipeline, hands registered operands to
//    an external multiplier core, waits for its result with a timeout, and
//    holds the 32-bit product in the HI/LO register pair. HI/LO can also be
//    written directly (MtHi/MtLo) while the controller is idle.
//
// Ports:
//    Clk, Rst                      clock, synchronous active-high reset
//    MultReq, OpA, OpB             pipeline multiply request and operands
//    MtHi, MtLo, HiIn, LoIn        direct HI/LO writes
//    Idle, Done, Produto           multiplier core status and product
//    St                            one-cycle start pulse to the core
//    Multiplicando, Multiplicador  registered operands to the core
//    Busy                          stall back to the pipeline
//    ResultValid                   one-cycle pulse when a multiply updates HI/LO
//    Err                           one-cycle pulse on core timeout
//    HiOut, LoOut                  HI/LO register contents

module mult_hilo_ctrl #(
   parameter int TIMEOUT = 40
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        MultReq,
   input  logic [15:0] OpA,
   input  logic [15:0] OpB,
   input  logic        MtHi,
   input  logic        MtLo,
   input  logic [15:0] HiIn,
   input  logic [15:0] LoIn,
   input  logic        Idle,
   input  logic        Done,
   input  logic [31:0] Produto,
   output logic        St,
   output logic [15:0] Multiplicando,
   output logic [15:0] Multiplicador,
   output logic        Busy,
   output logic        ResultValid,
   output logic        Err,
   output logic [15:0] HiOut,
   output logic [15:0] LoOut
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ZERO   = 3'd1,
      S_LAUNCH = 3'd2,
      S_WAIT   = 3'd3,
      S_WRITE  = 3'd4
   } state_t;

   state_t          state;
   state_t          nxt;
   logic [CW-1:0]   cnt;
   logic [15:0]     hi;
   logic [15:0]     lo;

   logic            accept;
   logic            op_zero;
   logic            mt_ok;
   logic            tmo;

   // A request is only taken while the core reports idle, so an operation
   // still in flight (e.g. across a reset) drains before a new start.
   assign accept  = (state == S_IDLE) && MultReq && Idle;
   assign op_zero = (OpA == 16'd0) || (OpB == 16'd0);
   // Direct writes lose to an accepted multiply in the same cycle.
   assign mt_ok   = (state == S_IDLE) && !accept;
   // Last permitted WAIT cycle with no result: abort now.
   assign tmo     = (state == S_WAIT) && !Done && (cnt == CW'(TIMEOUT - 1));

   // State register
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= S_IDLE;
      end else begin
         state <= nxt;
      end
   end

   // Next-state logic
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               // A zero operand needs no trip through the core.
               nxt = op_zero ? S_ZERO : S_LAUNCH;
            end
         end
         S_ZERO:   nxt = S_IDLE;
         S_LAUNCH: nxt = S_WAIT;
         S_WAIT: begin
            if (Done) begin
               nxt = S_WRITE;
            end else if (tmo) begin
               nxt = S_IDLE;
            end
         end
         S_WRITE:  nxt = S_IDLE;
         default:  nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      St          = 1'b0;
      Busy        = 1'b0;
      ResultValid = 1'b0;
      Err         = 1'b0;
      case (state)
         S_IDLE: begin
            // Hold the pipeline while it asks and the core is still draining.
            Busy = MultReq && !Idle;
         end
         S_ZERO: begin
            Busy        = 1'b1;
            ResultValid = 1'b1;
         end
         S_LAUNCH: begin
            Busy = 1'b1;
            St   = 1'b1;
         end
         S_WAIT: begin
            Busy = 1'b1;
            Err  = tmo;
         end
         S_WRITE: begin
            Busy        = 1'b1;
            ResultValid = 1'b1;
         end
         default: begin
            Busy = 1'b0;
         end
      endcase
   end

   // Operand registers: captured once on accept, held through LAUNCH and WAIT.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         Multiplicando <= 16'd0;
         Multiplicador <= 16'd0;
      end else if (accept) begin
         Multiplicando <= OpA;
         Multiplicador <= OpB;
      end
   end

   // Timeout counter: zeroed while launching so WAIT starts from 0.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt <= '0;
      end else if (state == S_LAUNCH) begin
         cnt <= '0;
      end else if (state == S_WAIT) begin
         cnt <= cnt + CW'(1);
      end
   end

   // HI/LO registers. Done is only honoured in WAIT, so a late result from an
   // aborted or reset operation can never land here.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         hi <= 16'd0;
         lo <= 16'd0;
      end else if (state == S_ZERO) begin
         hi <= 16'd0;
         lo <= 16'd0;
      end else if ((state == S_WAIT) && Done) begin
         hi <= Produto[31:16];
         lo <= Produto[15:0];
      end else if (mt_ok) begin
         if (MtHi) begin
            hi <= HiIn;
         end
         if (MtLo) begin
            lo <= LoIn;
         end
      end
   end

   assign HiOut = hi;
   assign LoOut = lo;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb/tb_mult_hilo_ctrl.sv - randomized self-checking bench for mult_hilo_ctrl

module tb_mult_hilo_ctrl;

   localparam int TO = 40;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        MultReq;
   logic [15:0] OpA;
   logic [15:0] OpB;
   logic        MtHi;
   logic        MtLo;
   logic [15:0] HiIn;
   logic [15:0] LoIn;
   logic        Idle;
   logic        Done;
   logic [31:0] Produto;
   logic        St;
   logic [15:0] Multiplicando;
   logic [15:0] Multiplicador;
   logic        Busy;
   logic        ResultValid;
   logic        Err;
   logic [15:0] HiOut;
   logic [15:0] LoOut;

   int checks   = 0;
   int failures = 0;

   // Reference HI/LO contents
   logic [15:0] exp_hi;
   logic [15:0] exp_lo;

   mult_hilo_ctrl #(.TIMEOUT(TO)) dut (
      .Clk(Clk), .Rst(Rst), .MultReq(MultReq), .OpA(OpA), .OpB(OpB),
      .MtHi(MtHi), .MtLo(MtLo), .HiIn(HiIn), .LoIn(LoIn), .Idle(Idle),
      .Done(Done), .Produto(Produto), .St(St), .Multiplicando(Multiplicando),
      .Multiplicador(Multiplicador), .Busy(Busy), .ResultValid(ResultValid),
      .Err(Err), .HiOut(HiOut), .LoOut(LoOut)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_hilo(input string tag);
      check({tag, "_hi"}, HiOut, exp_hi);
      check({tag, "_lo"}, LoOut, exp_lo);
   endtask

   // Direct HI/LO write while idle.
   task automatic do_mt(input bit wh, input bit wl, input logic [15:0] hv, input logic [15:0] lv);
      MtHi = wh; MtLo = wl; HiIn = hv; LoIn = lv;
      tick();
      MtHi = 1'b0; MtLo = 1'b0;
      if (wh) exp_hi = hv;
      if (wl) exp_lo = lv;
      check_hilo("mt");
      check("mt_rv", ResultValid, 0);
   endtask

   // Stale Done while idle must not change anything.
   task automatic stray_done();
      Done = 1'b1; Produto = $urandom;
      tick();
      Done = 1'b0;
      check("stray_rv", ResultValid, 0);
      check_hilo("stray");
   endtask

   // Pipeline asks while core is still busy: must stall, not start.
   task automatic stall_req(input int n);
      MultReq = 1'b1; Idle = 1'b0; OpA = $urandom; OpB = $urandom;
      for (int i = 0; i < n; i++) begin
         #1;
         check("stall_busy", Busy, 1);
         tick();
         check("stall_st", St, 0);
      end
      MultReq = 1'b0; Idle = 1'b1;
      #1;
      check("stall_release_busy", Busy, 0);
   endtask

   // One full multiply; core answers after lat extra WAIT cycles.
   task automatic do_mult(input logic [15:0] a, input logic [15:0] b, input int lat);
      logic [31:0] prod;
      bit zero;
      prod = 32'(a) * 32'(b);
      zero = (a == 16'd0) || (b == 16'd0);
      OpA = a; OpB = b; MultReq = 1'b1; Idle = 1'b1;
      // Direct writes in the accept cycle must be ignored.
      MtHi = 1'b1; MtLo = 1'b1; HiIn = ~exp_hi; LoIn = ~exp_lo;
      #1;
      check("accept_cycle_busy", Busy, 0);
      tick();
      MultReq = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
      OpA = $urandom; OpB = $urandom;
      check("opnd_a", Multiplicando, a);
      check("opnd_b", Multiplicador, b);
      check_hilo("accept_mt_ignored");
      if (zero) begin
         check("zero_st", St, 0);
         check("zero_rv", ResultValid, 1);
         check("zero_busy", Busy, 1);
         tick();
         exp_hi = 16'd0; exp_lo = 16'd0;
         check("zero_rv_after", ResultValid, 0);
         check("zero_busy_after", Busy, 0);
         check("zero_st_after", St, 0);
         check_hilo("zero_result");
         return;
      end
      check("launch_st", St, 1);
      check("launch_rv", ResultValid, 0);
      check("launch_busy", Busy, 1);
      tick();
      Idle = 1'b0;
      for (int i = 0; i < lat; i++) begin
         check("wait_st", St, 0);
         check("wait_rv", ResultValid, 0);
         check("wait_err", Err, 0);
         check("wait_busy", Busy, 1);
         check("wait_opnd_a", Multiplicando, a);
         check("wait_opnd_b", Multiplicador, b);
         check_hilo("wait_hold");
         MtHi = 1'($urandom); HiIn = $urandom;
         Produto = $urandom;
         tick();
         MtHi = 1'b0;
      end
      check("pre_done_opnd_b", Multiplicador, b);
      Done = 1'b1; Produto = prod;
      tick();
      Done = 1'b0; Idle = 1'b1; Produto = $urandom;
      exp_hi = prod[31:16]; exp_lo = prod[15:0];
      check("write_rv", ResultValid, 1);
      check("write_busy", Busy, 1);
      check("write_st", St, 0);
      check_hilo("write_result");
      tick();
      check("post_rv", ResultValid, 0);
      check("post_busy", Busy, 0);
      check_hilo("post_result");
   endtask

   // Core never answers: expect Err after exactly TO WAIT cycles.
   task automatic do_timeout(input logic [15:0] a, input logic [15:0] b);
      int n;
      OpA = a; OpB = b; MultReq = 1'b1; Idle = 1'b1;
      tick();
      MultReq = 1'b0; Idle = 1'b0;
      check("to_launch_st", St, 1);
      n = 0;
      while (n < TO + 5) begin
         Produto = $urandom;
         tick();
         n++;
         if (Err) break;
      end
      check("to_err_seen", Err, 1);
      check("to_wait_cycles", n, TO);
      check("to_err_busy", Busy, 1);
      tick();
      Idle = 1'b1;
      check("to_err_pulse", Err, 0);
      check("to_busy_drop", Busy, 0);
      check("to_rv", ResultValid, 0);
      check_hilo("to_hold");
   endtask

   task automatic reset_mid_wait();
      OpA = 16'd3; OpB = 16'd5; MultReq = 1'b1; Idle = 1'b1;
      tick();
      MultReq = 1'b0; Idle = 1'b0;
      tick();
      tick();
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      exp_hi = 16'd0; exp_lo = 16'd0;
      check("rst_st", St, 0);
      check("rst_busy", Busy, 0);
      check("rst_rv", ResultValid, 0);
      check("rst_err", Err, 0);
      check("rst_opnd_a", Multiplicando, 0);
      check("rst_opnd_b", Multiplicador, 0);
      check_hilo("rst");
      Done = 1'b1; Produto = 32'hDEAD_BEEF;
      tick();
      Done = 1'b0;
      check("rst_late_done_rv", ResultValid, 0);
      check_hilo("rst_late_done");
      // Core still busy: new request must wait.
      OpA = 16'd7; OpB = 16'd9; MultReq = 1'b1;
      #1;
      check("rst_drain_busy", Busy, 1);
      tick();
      check("rst_drain_st", St, 0);
      check("rst_drain_opnd", Multiplicando, 0);
      MultReq = 1'b0; Idle = 1'b1;
      do_mt(1'b1, 1'b0, 16'h1234, 16'h0000);
      check("rst_mthi", HiOut, 16'h1234);
   endtask

   initial begin
      Rst = 1'b1; MultReq = 1'b0; OpA = '0; OpB = '0; MtHi = 1'b0; MtLo = 1'b0;
      HiIn = '0; LoIn = '0; Idle = 1'b1; Done = 1'b0; Produto = '0;
      exp_hi = 16'd0; exp_lo = 16'd0;
      tick();
      tick();
      Rst = 1'b0;
      check("reset_st", St, 0);
      check("reset_busy", Busy, 0);
      check("reset_rv", ResultValid, 0);
      check("reset_err", Err, 0);
      check("reset_opnd_a", Multiplicando, 0);
      check("reset_opnd_b", Multiplicador, 0);
      check_hilo("reset");

      do_mult(16'd2, 16'd10, 3);
      check("dir_2x10", {HiOut, LoOut}, 32'h0000_0014);
      do_mult(16'd15, 16'd15, 0);
      check("dir_15x15", {HiOut, LoOut}, 32'h0000_00E1);
      do_mt(1'b1, 1'b1, 16'hAAAA, 16'h5555);
      do_mult(16'd0, 16'hFFFF, 0);
      check("dir_0xffff", {HiOut, LoOut}, 32'h0000_0000);
      do_mult(16'hFFFF, 16'hFFFF, 5);
      check("dir_ffffxffff", {HiOut, LoOut}, 32'hFFFE_0001);
      do_mult(16'h1234, 16'h0002, TO - 2);
      do_timeout(16'd9, 16'd9);
      reset_mid_wait();

      for (int t = 0; t < 40; t++) begin
         int kind;
         kind = int'($urandom_range(0, 9));
         if (kind == 0) begin
            do_mt(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
         end else if (kind == 1) begin
            stray_done();
         end else begin
            logic [15:0] a;
            logic [15:0] b;
            a = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            if (kind == 2) stall_req(int'($urandom_range(1, 3)));
            do_mult(a, b, int'($urandom_range(0, TO - 2)));
         end
      end
      do_timeout(16'hBEEF, 16'h0101);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
